// File: rtl/saturn_alu_pkg.sv
// Shared encodings for the Saturn nibble-serial ALU: instruction type, register
// selectors, opcodes and FSM states, plus small decode helpers.
package saturn_alu_pkg;

    localparam logic [3:0] INSTR_TYPE_ALU = 4'd1;

    localparam logic [4:0] ALU_REG_A    = 5'd0;
    localparam logic [4:0] ALU_REG_B    = 5'd1;
    localparam logic [4:0] ALU_REG_C    = 5'd2;
    localparam logic [4:0] ALU_REG_D    = 5'd3;
    localparam logic [4:0] ALU_REG_P    = 5'd4;
    localparam logic [4:0] ALU_REG_IMM  = 5'd5;
    localparam logic [4:0] ALU_REG_NONE = 5'd31;

    localparam logic [4:0] ALU_OP_NOP  = 5'd0;
    localparam logic [4:0] ALU_OP_COPY = 5'd1;
    localparam logic [4:0] ALU_OP_ADD  = 5'd2;
    localparam logic [4:0] ALU_OP_SUB  = 5'd3;
    localparam logic [4:0] ALU_OP_INC  = 5'd4;
    localparam logic [4:0] ALU_OP_DEC  = 5'd5;
    localparam logic [4:0] ALU_OP_ZERO = 5'd6;
    localparam logic [4:0] ALU_OP_EXCH = 5'd7;

    typedef enum logic [1:0] {
        ALU_IDLE = 2'd0,
        ALU_RUN  = 2'd1,
        ALU_DONE = 2'd2
    } alu_state_t;

    // A..D occupy codes 0..3 so the low two bits index the register file.
    function automatic logic is_work_reg(input logic [4:0] code);
        return code <= ALU_REG_D;
    endfunction

    function automatic logic is_arith(input logic [4:0] op);
        return (op == ALU_OP_ADD) || (op == ALU_OP_SUB) ||
               (op == ALU_OP_INC) || (op == ALU_OP_DEC);
    endfunction

endpackage

// File: rtl/saturn_alu_nibble.sv
// One-nibble hex adder/subtractor with carry chaining. Subtraction is done as
// a + ~b + cin, so the chained carry means "no borrow" for SUB and DEC.
module saturn_alu_nibble
    import saturn_alu_pkg::*;
(
    input  logic [4:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] res,
    output logic       cout
);

    logic [3:0] b_eff;
    logic [4:0] sum;

    always_comb begin
        b_eff = b;
        case (op)
            ALU_OP_SUB: b_eff = ~b;
            ALU_OP_INC: b_eff = 4'h0;
            ALU_OP_DEC: b_eff = 4'hF;
            default:    b_eff = b;
        endcase
        sum  = {1'b0, a} + {1'b0, b_eff} + {4'b0, cin};
        res  = a;
        cout = cin;
        if (is_arith(op)) begin
            res  = sum[3:0];
            cout = sum[4];
        end else if (op == ALU_OP_ZERO) begin
            res = 4'h0;
        end
    end

endmodule

// File: rtl/saturn_alu.sv
// Nibble-serial ALU execution stage: captures a decoded operation, then walks
// its nibble field one nibble per clock over A/B/C/D or P, chaining carry.
module saturn_alu
    import saturn_alu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_phases,
    input  logic [1:0]  i_phase,
    input  logic [31:0] i_cycle_ctr,
    input  logic        i_debug_cycle,
    input  logic        i_bus_busy,
    input  logic        i_instr_decoded,
    input  logic [3:0]  i_instr_type,
    input  logic [4:0]  i_alu_reg_dest,
    input  logic [4:0]  i_alu_reg_src_1,
    input  logic [4:0]  i_alu_reg_src_2,
    input  logic [3:0]  i_alu_imm_value,
    input  logic [4:0]  i_alu_opcode,
    input  logic [3:0]  i_alu_field_start,
    input  logic [3:0]  i_alu_field_end,
    output logic        o_alu_busy,
    output logic        o_alu_done,
    output logic        o_alu_illegal,
    output logic        o_carry,
    output logic [3:0]  o_reg_p,
    input  logic [1:0]  o_dbg_reg_sel,
    output logic [63:0] o_dbg_reg_value
);

    alu_state_t       state_reg, state_next;
    logic [3:0][63:0] regs_reg;
    logic [3:0]       p_reg;
    logic [4:0]       op_reg, dest_reg, src1_reg, src2_reg;
    logic [3:0]       imm_reg, ptr_reg, end_reg;
    logic             chain_reg, carry_reg, illegal_reg;

    logic stall, capture_req, dest_is_p, bad_op, accept, illegal_next;
    logic [3:0] eff_start, eff_end;
    logic [3:0] src1_nib, src2_nib, dest_nib, nib_res;
    logic       nib_cout;
    logic       unused_inputs;

    assign unused_inputs = ^{i_phase, i_cycle_ctr, i_phases[2:0]};

    function automatic logic [3:0] fetch_nibble(input logic [4:0] code,
                                                input logic [3:0][63:0] regs,
                                                input logic [3:0] p,
                                                input logic [3:0] imm,
                                                input logic [3:0] ptr);
        logic [3:0] val;
        val = 4'h0;
        if (is_work_reg(code))
            val = regs[code[1:0]][{ptr, 2'b00} +: 4];
        else if (code == ALU_REG_P)
            val = (ptr == 4'd0) ? p : 4'h0;
        else if (code == ALU_REG_IMM)
            val = imm;
        return val;
    endfunction

    assign stall       = i_debug_cycle || i_bus_busy;
    assign capture_req = i_instr_decoded && i_phases[3] && (i_instr_type == INSTR_TYPE_ALU);
    assign dest_is_p   = (i_alu_reg_dest == ALU_REG_P);
    // P is a single nibble, so whatever field the decoder supplies is ignored.
    assign eff_start   = dest_is_p ? 4'd0 : i_alu_field_start;
    assign eff_end     = dest_is_p ? 4'd0 : i_alu_field_end;

    assign bad_op = (eff_start > eff_end) ||
                    !(is_work_reg(i_alu_reg_dest) || dest_is_p) ||
                    ((i_alu_opcode == ALU_OP_EXCH) &&
                     (dest_is_p || i_alu_reg_src_1 == ALU_REG_P ||
                      i_alu_reg_src_1 == ALU_REG_IMM)) ||
                    (i_alu_opcode > ALU_OP_EXCH);

    assign accept       = capture_req && !stall && (state_reg == ALU_IDLE) && !bad_op;
    assign illegal_next = capture_req && !stall && ((state_reg != ALU_IDLE) || bad_op);

    assign src1_nib = fetch_nibble(src1_reg, regs_reg, p_reg, imm_reg, ptr_reg);
    assign src2_nib = fetch_nibble(src2_reg, regs_reg, p_reg, imm_reg, ptr_reg);
    assign dest_nib = fetch_nibble(dest_reg, regs_reg, p_reg, imm_reg, ptr_reg);

    saturn_alu_nibble u_nibble (
        .op   (op_reg),
        .a    (src1_nib),
        .b    (src2_nib),
        .cin  (chain_reg),
        .res  (nib_res),
        .cout (nib_cout)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            state_reg <= ALU_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (!stall) begin
            case (state_reg)
                ALU_IDLE: if (accept) state_next = ALU_RUN;
                ALU_RUN:  if (ptr_reg == end_reg) state_next = ALU_DONE;
                ALU_DONE: state_next = ALU_IDLE;
                default:  state_next = ALU_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            regs_reg    <= '0;
            p_reg       <= 4'h0;
            op_reg      <= ALU_OP_NOP;
            dest_reg    <= ALU_REG_NONE;
            src1_reg    <= ALU_REG_NONE;
            src2_reg    <= ALU_REG_NONE;
            imm_reg     <= 4'h0;
            ptr_reg     <= 4'd0;
            end_reg     <= 4'd0;
            chain_reg   <= 1'b0;
            carry_reg   <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            illegal_reg <= illegal_next;
            if (accept) begin
                op_reg    <= i_alu_opcode;
                dest_reg  <= i_alu_reg_dest;
                src1_reg  <= i_alu_reg_src_1;
                src2_reg  <= i_alu_reg_src_2;
                imm_reg   <= i_alu_imm_value;
                ptr_reg   <= eff_start;
                end_reg   <= eff_end;
                chain_reg <= (i_alu_opcode == ALU_OP_INC) || (i_alu_opcode == ALU_OP_SUB);
            end else if (!stall && state_reg == ALU_RUN) begin
                if (op_reg != ALU_OP_NOP) begin
                    if (dest_reg == ALU_REG_P)
                        p_reg <= nib_res;
                    else
                        regs_reg[dest_reg[1:0]][{ptr_reg, 2'b00} +: 4] <= nib_res;
                    if (op_reg == ALU_OP_EXCH && is_work_reg(src1_reg))
                        regs_reg[src1_reg[1:0]][{ptr_reg, 2'b00} +: 4] <= dest_nib;
                end
                chain_reg <= nib_cout;
                ptr_reg   <= ptr_reg + 4'd1;
                // Reported carry is a borrow for the subtracting ops.
                if (ptr_reg == end_reg && is_arith(op_reg))
                    carry_reg <= (op_reg == ALU_OP_SUB || op_reg == ALU_OP_DEC) ? ~nib_cout : nib_cout;
            end
        end
    end

    assign o_alu_busy      = (state_reg != ALU_IDLE);
    assign o_alu_done      = (state_reg == ALU_DONE) && !stall;
    assign o_alu_illegal   = illegal_reg;
    assign o_carry         = carry_reg;
    assign o_reg_p         = p_reg;
    assign o_dbg_reg_value = regs_reg[o_dbg_reg_sel];

endmodule

// File: tb/tb_saturn_alu.sv
// Directed bench for saturn_alu: table of operations with hand-computed
// register/carry/latency results, plus stall, collision and async-reset cases.
module tb_saturn_alu;
    import saturn_alu_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [3:0]  i_phases;
    logic [1:0]  i_phase;
    logic [31:0] i_cycle_ctr;
    logic        i_debug_cycle, i_bus_busy, i_instr_decoded;
    logic [3:0]  i_instr_type;
    logic [4:0]  i_alu_reg_dest, i_alu_reg_src_1, i_alu_reg_src_2;
    logic [3:0]  i_alu_imm_value;
    logic [4:0]  i_alu_opcode;
    logic [3:0]  i_alu_field_start, i_alu_field_end;
    logic        o_alu_busy, o_alu_done, o_alu_illegal, o_carry;
    logic [3:0]  o_reg_p;
    logic [1:0]  o_dbg_reg_sel;
    logic [63:0] o_dbg_reg_value;

    always #5 i_clk = ~i_clk;

    saturn_alu dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_phases(i_phases), .i_phase(i_phase),
        .i_cycle_ctr(i_cycle_ctr), .i_debug_cycle(i_debug_cycle), .i_bus_busy(i_bus_busy),
        .i_instr_decoded(i_instr_decoded), .i_instr_type(i_instr_type),
        .i_alu_reg_dest(i_alu_reg_dest), .i_alu_reg_src_1(i_alu_reg_src_1),
        .i_alu_reg_src_2(i_alu_reg_src_2), .i_alu_imm_value(i_alu_imm_value),
        .i_alu_opcode(i_alu_opcode), .i_alu_field_start(i_alu_field_start),
        .i_alu_field_end(i_alu_field_end), .o_alu_busy(o_alu_busy), .o_alu_done(o_alu_done),
        .o_alu_illegal(o_alu_illegal), .o_carry(o_carry), .o_reg_p(o_reg_p),
        .o_dbg_reg_sel(o_dbg_reg_sel), .o_dbg_reg_value(o_dbg_reg_value)
    );

    typedef struct {
        logic [4:0]  op, dest, s1, s2;
        logic [3:0]  imm, fs, fe;
        logic        illegal;
        logic [63:0] ea, eb, ec, ed;
        logic [3:0]  ep;
        logic        ecarry;
        int          ecyc;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [4:0] dest, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [3:0] imm, input logic [3:0] fs,
                         input logic [3:0] fe);
        i_alu_opcode = op; i_alu_reg_dest = dest; i_alu_reg_src_1 = s1; i_alu_reg_src_2 = s2;
        i_alu_imm_value = imm; i_alu_field_start = fs; i_alu_field_end = fe;
        i_instr_type = INSTR_TYPE_ALU; i_phases = 4'b1000; i_instr_decoded = 1'b1;
        tick();
        i_instr_decoded = 1'b0; i_phases = 4'b0001;
    endtask

    // Counts busy samples from the capture edge through the done pulse.
    task automatic wait_done(input string name, input int exp_cyc, inout int cyc);
        while (!o_alu_done && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({name, "_done"}, 64'(o_alu_done), 64'd1);
        chk({name, "_cycles"}, 64'(cyc), 64'(exp_cyc));
        tick();
        chk({name, "_idle"}, 64'({o_alu_busy, o_alu_done}), 64'd0);
    endtask

    task automatic check_regs(input string name, input logic [63:0] ea, input logic [63:0] eb,
                              input logic [63:0] ec, input logic [63:0] ed);
        logic [63:0] exp_r [4];
        exp_r[0] = ea; exp_r[1] = eb; exp_r[2] = ec; exp_r[3] = ed;
        for (int j = 0; j < 4; j++) begin
            o_dbg_reg_sel = 2'(j);
            #1;
            chk($sformatf("%s_reg%0d", name, j), o_dbg_reg_value, exp_r[j]);
        end
    endtask

    function automatic vec_t mk(logic [4:0] op, logic [4:0] dest, logic [4:0] s1, logic [4:0] s2,
                                logic [3:0] imm, logic [3:0] fs, logic [3:0] fe, logic ill,
                                logic [63:0] ea, logic [63:0] eb, logic [63:0] ec,
                                logic [63:0] ed, logic [3:0] ep, logic ec_, int cyc);
        vec_t v;
        v.op = op; v.dest = dest; v.s1 = s1; v.s2 = s2; v.imm = imm; v.fs = fs; v.fe = fe;
        v.illegal = ill; v.ea = ea; v.eb = eb; v.ec = ec; v.ed = ed; v.ep = ep;
        v.ecarry = ec_; v.ecyc = cyc;
        return v;
    endfunction

    initial begin
        int cyc;
        i_reset = 1'b0; i_phases = 4'b0001; i_phase = 2'd0; i_cycle_ctr = 32'd0;
        i_debug_cycle = 1'b0; i_bus_busy = 1'b0; i_instr_decoded = 1'b0;
        i_instr_type = 4'd0; i_alu_reg_dest = ALU_REG_NONE; i_alu_reg_src_1 = ALU_REG_NONE;
        i_alu_reg_src_2 = ALU_REG_NONE; i_alu_imm_value = 4'h0; i_alu_opcode = ALU_OP_NOP;
        i_alu_field_start = 4'd0; i_alu_field_end = 4'd0; o_dbg_reg_sel = 2'd0;

        vecs[0]  = mk(ALU_OP_COPY, ALU_REG_P, ALU_REG_IMM, ALU_REG_NONE, 4'h7, 4'd0, 4'd0, 1'b0,
                      64'h0, 64'h0, 64'h0, 64'h0, 4'h7, 1'b0, 2);
        vecs[1]  = mk(ALU_OP_COPY, ALU_REG_A, ALU_REG_IMM, ALU_REG_NONE, 4'hF, 4'd0, 4'd2, 1'b0,
                      64'h0FFF, 64'h0, 64'h0, 64'h0, 4'h7, 1'b0, 4);
        vecs[2]  = mk(ALU_OP_INC, ALU_REG_A, ALU_REG_A, ALU_REG_NONE, 4'h0, 4'd0, 4'd3, 1'b0,
                      64'h1000, 64'h0, 64'h0, 64'h0, 4'h7, 1'b0, 5);
        vecs[3]  = mk(ALU_OP_COPY, ALU_REG_B, ALU_REG_IMM, ALU_REG_NONE, 4'h1, 4'd0, 4'd0, 1'b0,
                      64'h1000, 64'h1, 64'h0, 64'h0, 4'h7, 1'b0, 2);
        vecs[4]  = mk(ALU_OP_ZERO, ALU_REG_A, ALU_REG_NONE, ALU_REG_NONE, 4'h0, 4'd0, 4'd15, 1'b0,
                      64'h0, 64'h1, 64'h0, 64'h0, 4'h7, 1'b0, 17);
        vecs[5]  = mk(ALU_OP_SUB, ALU_REG_A, ALU_REG_A, ALU_REG_B, 4'h0, 4'd0, 4'd15, 1'b0,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'h0, 4'h7, 1'b1, 17);
        vecs[6]  = mk(ALU_OP_ADD, ALU_REG_C, ALU_REG_A, ALU_REG_B, 4'h0, 4'd4, 4'd7, 1'b0,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'hFFFF_0000, 64'h0, 4'h7, 1'b0, 5);
        vecs[7]  = mk(ALU_OP_DEC, ALU_REG_D, ALU_REG_D, ALU_REG_NONE, 4'h0, 4'd0, 4'd3, 1'b0,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'hFFFF_0000, 64'hFFFF, 4'h7, 1'b1, 5);
        vecs[8]  = mk(ALU_OP_EXCH, ALU_REG_C, ALU_REG_D, ALU_REG_NONE, 4'h0, 4'd4, 4'd7, 1'b0,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'hFFFF_FFFF, 4'h7, 1'b1, 5);
        vecs[9]  = mk(ALU_OP_ADD, ALU_REG_A, ALU_REG_A, ALU_REG_IMM, 4'h1, 4'd0, 4'd15, 1'b0,
                      64'h1111_1111_1111_1110, 64'h1, 64'h0, 64'hFFFF_FFFF, 4'h7, 1'b1, 17);
        vecs[10] = mk(ALU_OP_NOP, ALU_REG_A, ALU_REG_A, ALU_REG_NONE, 4'h0, 4'd0, 4'd1, 1'b0,
                      64'h1111_1111_1111_1110, 64'h1, 64'h0, 64'hFFFF_FFFF, 4'h7, 1'b1, 3);
        vecs[11] = mk(ALU_OP_ADD, ALU_REG_P, ALU_REG_P, ALU_REG_IMM, 4'h3, 4'd3, 4'd3, 1'b0,
                      64'h1111_1111_1111_1110, 64'h1, 64'h0, 64'hFFFF_FFFF, 4'hA, 1'b0, 2);
        vecs[12] = mk(ALU_OP_COPY, ALU_REG_A, ALU_REG_IMM, ALU_REG_NONE, 4'h5, 4'd5, 4'd3, 1'b1,
                      64'h1111_1111_1111_1110, 64'h1, 64'h0, 64'hFFFF_FFFF, 4'hA, 1'b0, 0);
        vecs[13] = mk(ALU_OP_COPY, ALU_REG_IMM, ALU_REG_A, ALU_REG_NONE, 4'h5, 4'd0, 4'd3, 1'b1,
                      64'h1111_1111_1111_1110, 64'h1, 64'h0, 64'hFFFF_FFFF, 4'hA, 1'b0, 0);
        vecs[14] = mk(ALU_OP_EXCH, ALU_REG_A, ALU_REG_IMM, ALU_REG_NONE, 4'h5, 4'd0, 4'd3, 1'b1,
                      64'h1111_1111_1111_1110, 64'h1, 64'h0, 64'hFFFF_FFFF, 4'hA, 1'b0, 0);
        vecs[15] = mk(5'd31, ALU_REG_A, ALU_REG_B, ALU_REG_NONE, 4'h5, 4'd0, 4'd3, 1'b1,
                      64'h1111_1111_1111_1110, 64'h1, 64'h0, 64'hFFFF_FFFF, 4'hA, 1'b0, 0);

        tick(); tick();
        chk("rst_outputs", 64'({o_alu_busy, o_alu_done, o_alu_illegal, o_carry, o_reg_p}), 64'd0);
        check_regs("rst", 64'h0, 64'h0, 64'h0, 64'h0);
        i_reset = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            issue(vecs[i].op, vecs[i].dest, vecs[i].s1, vecs[i].s2,
                  vecs[i].imm, vecs[i].fs, vecs[i].fe);
            chk({nm, "_illegal"}, 64'(o_alu_illegal), 64'(vecs[i].illegal));
            if (vecs[i].illegal) begin
                chk({nm, "_busy"}, 64'(o_alu_busy), 64'd0);
                tick();
                chk({nm, "_pulse_end"}, 64'({o_alu_illegal, o_alu_busy}), 64'd0);
            end else begin
                cyc = 1;
                wait_done(nm, vecs[i].ecyc, cyc);
            end
            chk({nm, "_p"}, 64'(o_reg_p), 64'(vecs[i].ep));
            chk({nm, "_carry"}, 64'(o_carry), 64'(vecs[i].ecarry));
            check_regs(nm, vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ed);
            $display("vec %0d op=%0d dest=%0d field=%0d..%0d done, passed %0d/%0d",
                     i, vecs[i].op, vecs[i].dest, vecs[i].fs, vecs[i].fe, n_pass, n_total);
        end

        // Colliding strobe plus a 3-clock bus stall during COPY B=A over nibbles 0..7.
        issue(ALU_OP_COPY, ALU_REG_B, ALU_REG_A, ALU_REG_NONE, 4'h0, 4'd0, 4'd7);
        cyc = 1;
        i_instr_decoded = 1'b1; i_phases = 4'b1000;
        tick(); cyc++;
        i_instr_decoded = 1'b0; i_phases = 4'b0001;
        chk("collide_illegal", 64'(o_alu_illegal), 64'd1);
        i_bus_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); cyc++;
            chk($sformatf("stall%0d_busy_nodone", k), 64'({o_alu_busy, o_alu_done}), 64'b10);
        end
        i_bus_busy = 1'b0;
        wait_done("stall", 12, cyc);
        check_regs("stall", 64'h1111_1111_1111_1110, 64'h1111_1110, 64'h0, 64'hFFFF_FFFF);
        $display("seq collide+stall done, passed %0d/%0d", n_pass, n_total);

        // Asynchronous reset in the middle of COPY A=D.
        issue(ALU_OP_COPY, ALU_REG_A, ALU_REG_D, ALU_REG_NONE, 4'h0, 4'd0, 4'd15);
        tick(); tick(); tick();
        #2;
        i_reset = 1'b0;
        #1;
        chk("arst_outputs", 64'({o_alu_busy, o_alu_done, o_alu_illegal, o_carry, o_reg_p}), 64'd0);
        check_regs("arst", 64'h0, 64'h0, 64'h0, 64'h0);
        tick();
        i_reset = 1'b1;
        tick(); tick();
        chk("arst_idle", 64'(o_alu_busy), 64'd0);
        check_regs("arst_post", 64'h0, 64'h0, 64'h0, 64'h0);
        $display("seq async reset done, passed %0d/%0d", n_pass, n_total);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
